// File: rtl/truth_table_sweeper_if.sv
// Handshake/data bundle between a sweep requester and the truth-table sweeper.
// master = requester and function-under-test side, slave = sweeper.
interface truth_table_sweeper_if #(
  parameter int N = 3
);
  localparam int W = 1 << N;

  logic         start;
  logic         abort;
  logic [W-1:0] expected;
  logic         f_in;
  logic [N-1:0] x_out;
  logic         busy;
  logic         done;
  logic [W-1:0] table_out;
  logic         mismatch;
  logic [N:0]   err_count;

  modport master (
    output start, abort, expected, f_in,
    input  x_out, busy, done, table_out, mismatch, err_count
  );

  modport slave (
    input  start, abort, expected, f_in,
    output x_out, busy, done, table_out, mismatch, err_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper with settle time and minterm-mask compare.
// Define SWEEP_GRAY_EN to sweep in reflected Gray order instead of binary.
module truth_table_sweeper #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam int W  = 1 << N;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);
  localparam logic [N-1:0]  ONE    = N'(1);
  localparam logic [N-1:0]  LASTI  = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q;
  logic [N-1:0]  idx_q;
  logic [N-1:0]  x_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  exp_q;
  logic [W-1:0]  tbl_q;
  logic          busy_q;
  logic          done_q;
  logic          mm_q;
  logic [N:0]    ec_q;

  logic [W-1:0]  tbl_d;
  logic [W-1:0]  diff_d;

  function automatic logic [N-1:0] code(
    input logic [N-1:0] k
  );
`ifdef SWEEP_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  function automatic logic [N:0] pop(
    input logic [W-1:0] v
  );
    logic [N:0] c;
    c = '0;
    for (int i = 0; i < W; i++)
      c = c + (N+1)'(v[i]);
    return c;
  endfunction

  // Table as it will look once the current sample lands
  always_comb begin
    tbl_d        = tbl_q;
    tbl_d[x_q]   = bus.f_in;
    diff_d       = tbl_d ^ exp_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mm_q    <= 1'b0;
      ec_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            exp_q   <= bus.expected;
            tbl_q   <= '0;
            mm_q    <= 1'b0;
            ec_q    <= '0;
            idx_q   <= '0;
            x_q     <= code('0);
            cnt_q   <= RELOAD;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            x_q     <= '0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            tbl_q <= tbl_d;
            if (idx_q == LASTI) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              mm_q    <= |diff_d;
              ec_q    <= pop(diff_d);
            end else begin
              idx_q <= idx_q + ONE;
              x_q   <= code(idx_q + ONE);
              cnt_q <= RELOAD;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_out     = x_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = tbl_q;
  assign bus.mismatch  = mm_q;
  assign bus.err_count = ec_q;
endmodule
